// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM master: frame command codes, widths and FSM states.
package spi_ram_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_SHIFT,
    ST_TURN,
    ST_RDATA,
    ST_GAP
  } state_e;

  function automatic logic [FRAME_W-1:0] make_frame(input logic [1:0]        cmd,
                                                     input logic [DATA_W-1:0] payload);
    return {cmd, payload};
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// 10-bit parallel-in/serial-out command shifter and 8-bit serial-in read-data shifter.
module spi_frame_shifter
  import spi_ram_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [FRAME_W-1:0] i_frame,
  input  logic               i_shift,
  input  logic               i_sample,
  input  logic               i_miso,
  output logic               o_mosi,
  output logic [DATA_W-1:0]  o_rdata,
  output logic               o_done
);

  localparam logic [3:0] TX_LAST = 4'(FRAME_W - 1);
  localparam logic [2:0] RX_LAST = 3'(DATA_W - 1);

  logic [FRAME_W-1:0] r_piso;
  logic [3:0]         r_tx_cnt;
  logic [DATA_W-1:0]  r_sipo;
  logic [2:0]         r_rx_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of the order the blocks execute in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_piso   <= '0;
      r_tx_cnt <= '0;
      r_sipo   <= '0;
      r_rx_cnt <= '0;
    end else if (i_load) begin
      r_piso   <= i_frame;
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (i_shift) begin
        r_piso   <= {r_piso[FRAME_W-2:0], 1'b0};
        r_tx_cnt <= r_tx_cnt + 4'd1;
      end
      // MISO is only looked at while sampling, so an undriven line never reaches r_sipo.
      if (i_sample) begin
        r_sipo   <= {r_sipo[DATA_W-2:0], i_miso};
        r_rx_cnt <= r_rx_cnt + 3'd1;
      end
    end
  end

  assign o_mosi  = r_piso[FRAME_W-1];
  assign o_rdata = r_sipo;
  assign o_done  = (i_shift  && (r_tx_cnt == TX_LAST)) ||
                   (i_sample && (r_rx_cnt == RX_LAST));

endmodule

// File: rtl/spi_ram_master.sv
// Host-side SPI master: turns one read/write request into 10-bit command frames
// for the SPI RAM slave and returns the read byte as a one-cycle response.
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int PRE_CYC   = 2,
  parameter int TURN_CYC  = 1,
  parameter int GAP_CYC   = 1,
  parameter bit ADDR_SKIP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam logic [3:0] PRE_LAST  = 4'(PRE_CYC - 1);
  localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYC - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [3:0]         r_cyc;
  logic [FRAME_W-1:0] r_frame0;
  logic [FRAME_W-1:0] r_frame1;
  logic               r_fidx;
  logic               r_is_read;
  logic [DATA_W-1:0]  r_wr_cache;
  logic               r_wr_vld;
  logic [DATA_W-1:0]  r_rd_cache;
  logic               r_rd_vld;

  logic [FRAME_W-1:0] w_cur_frame;
  logic [1:0]         w_cur_cmd;
  logic               w_accept;
  logic               w_skip;
  logic               w_load;
  logic               w_shift;
  logic               w_sample;
  logic               w_done;
  logic               w_mosi;
  logic [DATA_W-1:0]  w_rdata;
  logic               w_gap_end;

  // r_fidx=1 selects the data frame, which is always the last one of a request.
  assign w_cur_frame = r_fidx ? r_frame1 : r_frame0;
  assign w_cur_cmd   = w_cur_frame[FRAME_W-1 -: 2];
  assign w_accept    = req_valid && (r_state == ST_IDLE);
  assign w_skip      = ADDR_SKIP &&
                       (req_write ? (r_wr_vld && (r_wr_cache == req_addr))
                                  : (r_rd_vld && (r_rd_cache == req_addr)));

  // Shifter controls decode straight from the state register to keep the
  // done flag out of a combinational loop with the next-state logic.
  assign w_load    = (r_state == ST_SEL);
  assign w_shift   = (r_state == ST_SHIFT);
  assign w_sample  = (r_state == ST_RDATA);
  assign w_gap_end = (r_state == ST_GAP) && (r_cyc == GAP_LAST);

  spi_frame_shifter u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_frame  (w_cur_frame),
    .i_shift  (w_shift),
    .i_sample (w_sample),
    .i_miso   (MISO),
    .o_mosi   (w_mosi),
    .o_rdata  (w_rdata),
    .o_done   (w_done)
  );

  // NOTE: the default assignment ahead of the case keeps every path assigned,
  // so no latch is inferred for the next-state value.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (req_valid) w_state_nxt = ST_SEL;
      ST_SEL:   if (r_cyc == PRE_LAST) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_done) w_state_nxt = ST_TURN;
      ST_TURN:  if (r_cyc == TURN_LAST)
                  w_state_nxt = (w_cur_cmd == CMD_RD_DATA) ? ST_RDATA : ST_GAP;
      ST_RDATA: if (w_done) w_state_nxt = ST_GAP;
      ST_GAP:   if (w_gap_end) w_state_nxt = r_fidx ? ST_IDLE : ST_SEL;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cyc     <= '0;
      r_frame0  <= '0;
      r_frame1  <= '0;
      r_fidx    <= 1'b0;
      r_is_read <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cyc     <= (w_state_nxt != r_state) ? 4'd0 : r_cyc + 4'd1;
      rsp_valid <= w_gap_end && r_fidx;
      if (w_gap_end && r_fidx && r_is_read) rsp_rdata <= w_rdata;
      if (w_gap_end && !r_fidx) r_fidx <= 1'b1;
      if (w_accept) begin
        r_is_read <= !req_write;
        r_fidx    <= w_skip;
        if (req_write) begin
          r_frame0 <= make_frame(CMD_WR_ADDR, req_addr);
          r_frame1 <= make_frame(CMD_WR_DATA, req_wdata);
        end else begin
          r_frame0 <= make_frame(CMD_RD_ADDR, req_addr);
          r_frame1 <= make_frame(CMD_RD_DATA, '0);
        end
      end
    end
  end

  // Caches mirror the slave's separate write/read address registers and
  // only change once an address frame has been fully shifted out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cache <= '0;
      r_wr_vld   <= 1'b0;
      r_rd_cache <= '0;
      r_rd_vld   <= 1'b0;
    end else if (w_shift && w_done) begin
      if (w_cur_cmd == CMD_WR_ADDR) begin
        r_wr_cache <= w_cur_frame[DATA_W-1:0];
        r_wr_vld   <= 1'b1;
      end
      if (w_cur_cmd == CMD_RD_ADDR) begin
        r_rd_cache <= w_cur_frame[DATA_W-1:0];
        r_rd_vld   <= 1'b1;
      end
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign SS_n      = (r_state == ST_IDLE) || (r_state == ST_GAP);
  assign MOSI      = w_shift && w_mosi;

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench for spi_ram_master against a behavioural SPI RAM slave that
// decodes the 10-bit command frames and answers read-data frames on MISO.
module tb_spi_ram_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  int checks   = 0;
  int failures = 0;
  int n;
  int n2;

  spi_ram_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #5 clk = ~clk;

  // Slave model: counts SS_n-low edges; edges 0-1 are the select lead-in,
  // 2-11 carry the frame MSB first, 12-19 return read data on MISO.
  logic [7:0] m_ram [256];
  logic [8:0] m_sr = '0;
  logic [7:0] m_wa = '0;
  logic [7:0] m_ra = '0;
  logic       m_is_rd = 1'b0;
  logic       preload;
  int         m_cnt = 0;
  int         m_hi = 0;
  int         m_sel_bad = 0;
  logic [9:0] m_frames[$];
  int         m_gaps[$];

  always @(posedge clk) begin
    if (preload) for (int i = 0; i < 256; i++) m_ram[i] <= ~i[7:0];
    if (SS_n) begin
      m_cnt   <= 0;
      m_is_rd <= 1'b0;
      m_hi    <= m_hi + 1;
      MISO    <= 1'bx;
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 0) begin
        m_gaps.push_back(m_hi);
        m_hi <= 0;
      end
      if (m_cnt < 2 && MOSI) m_sel_bad <= m_sel_bad + 1;
      if (m_cnt >= 2 && m_cnt <= 11) m_sr <= {m_sr[7:0], MOSI};
      if (m_cnt == 11) begin
        m_frames.push_back({m_sr, MOSI});
        case (m_sr[8:7])
          2'b00:   m_wa <= {m_sr[6:0], MOSI};
          2'b01:   m_ram[m_wa] <= {m_sr[6:0], MOSI};
          2'b10:   m_ra <= {m_sr[6:0], MOSI};
          default: m_is_rd <= 1'b1;
        endcase
      end
      if (m_is_rd && m_cnt >= 12 && m_cnt <= 19) MISO <= m_ram[m_ra][19 - m_cnt];
      else MISO <= 1'bx;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns just after its accept edge (E0).
  task automatic send(input logic wr, input logic [7:0] a, input logic [7:0] d);
    int w;
    m_frames.delete();
    m_gaps.delete();
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) check("accept_timeout", 32'(w), 32'd0);
    tick();
    req_valid = 1'b0;
  endtask

  // Counts edges after E0 until rsp_valid is seen; start = edges already elapsed.
  task automatic wait_rsp(input int start, output int cnt);
    cnt = start;
    do begin
      tick();
      cnt++;
    end while (!rsp_valid && cnt < 200);
  endtask

  initial begin
    preload   = 1'b1;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    tick(); tick(); tick();
    preload = 1'b0;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'h00);
    check("rst_ss_n", 32'(SS_n), 32'd1);
    check("rst_mosi", 32'(MOSI), 32'd0);
    rst_n = 1'b1;
    tick(); tick();

    // 1: write 0x03 = 0xB7 with address frame
    send(1'b1, 8'h03, 8'hB7);
    check("t1_busy", 32'(req_ready), 32'd0);
    wait_rsp(0, n);
    check("t1_latency", 32'(n), 32'd28);
    check("t1_nframes", 32'(m_frames.size()), 32'd2);
    check("t1_frame0", 32'(m_frames[0]), 32'h003);
    check("t1_frame1", 32'(m_frames[1]), 32'h1B7);
    check("t1_gap", 32'(m_gaps[1]), 32'd1);
    check("t1_ram", 32'(m_ram[8'h03]), 32'hB7);
    tick();
    check("t1_rsp_pulse", 32'(rsp_valid), 32'd0);

    // 2: read back 0x03
    send(1'b0, 8'h03, 8'h00);
    wait_rsp(0, n);
    check("t2_latency", 32'(n), 32'd36);
    check("t2_rdata", 32'(rsp_rdata), 32'hB7);
    check("t2_frame0", 32'(m_frames[0]), 32'h203);
    check("t2_frame1", 32'(m_frames[1]), 32'h300);

    // 3: repeat write to 0x03, both address frames skipped
    send(1'b1, 8'h03, 8'h5A);
    wait_rsp(0, n);
    check("t3_w_latency", 32'(n), 32'd14);
    check("t3_w_nframes", 32'(m_frames.size()), 32'd1);
    check("t3_w_frame", 32'(m_frames[0]), 32'h15A);
    send(1'b0, 8'h03, 8'h00);
    wait_rsp(0, n);
    check("t3_r_latency", 32'(n), 32'd22);
    check("t3_r_rdata", 32'(rsp_rdata), 32'h5A);
    check("t3_r_frame", 32'(m_frames[0]), 32'h300);

    // 4: reset during the 5th SHIFT cycle of a (skipped-address) write
    send(1'b1, 8'h03, 8'hEE);
    repeat (6) tick();
    check("t4_pre_ss_n", 32'(SS_n), 32'd0);
    check("t4_pre_mosi", 32'(MOSI), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_ss_n", 32'(SS_n), 32'd1);
    check("t4_mosi", 32'(MOSI), 32'd0);
    tick(); tick();
    check("t4_no_rsp", 32'(rsp_valid), 32'd0);
    #2 rst_n = 1'b1;
    tick(); tick();
    check("t4_ram_kept", 32'(m_ram[8'h03]), 32'h5A);
    send(1'b1, 8'h03, 8'hEE);
    wait_rsp(0, n);
    check("t4_latency", 32'(n), 32'd28);
    check("t4_frame0", 32'(m_frames[0]), 32'h003);
    check("t4_ram", 32'(m_ram[8'h03]), 32'hEE);

    // 5: request pulsed while busy is ignored; held request starts back-to-back
    send(1'b1, 8'h40, 8'h11);
    tick(); tick();
    req_write = 1'b1; req_addr = 8'h42; req_wdata = 8'h33; req_valid = 1'b1;
    check("t5_busy", 32'(req_ready), 32'd0);
    tick();
    req_valid = 1'b0;
    req_write = 1'b1; req_addr = 8'h41; req_wdata = 8'h22; req_valid = 1'b1;
    wait_rsp(3, n);
    check("t5_latency0", 32'(n), 32'd28);
    check("t5_ready_at_rsp", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("t5_accepted", 32'(req_ready), 32'd0);
    wait_rsp(0, n2);
    check("t5_latency1", 32'(n2), 32'd28);
    check("t5_ram40", 32'(m_ram[8'h40]), 32'h11);
    check("t5_ram41", 32'(m_ram[8'h41]), 32'h22);
    check("t5_ram42", 32'(m_ram[8'h42]), 32'hBD);

    // 6: read cache is independent of the write cache
    send(1'b1, 8'h10, 8'hC3);
    wait_rsp(0, n);
    check("t6_w_latency", 32'(n), 32'd28);
    send(1'b0, 8'h20, 8'h00);
    wait_rsp(0, n);
    check("t6_r20_latency", 32'(n), 32'd36);
    check("t6_r20_rdata", 32'(rsp_rdata), 32'hDF);
    send(1'b0, 8'h10, 8'h00);
    wait_rsp(0, n);
    check("t6_r10_latency", 32'(n), 32'd36);
    check("t6_r10_frame0", 32'(m_frames[0]), 32'h210);
    check("t6_r10_rdata", 32'(rsp_rdata), 32'hC3);

    check("sel_mosi_low", 32'(m_sel_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
